// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - 16x16 one-bit sprite rasteriser into an 8bpp framebuffer write port
// Optional erase of the previous sprite box is built only when BLIT_ERASE_EN is defined.
module sprite_blitter #(
  parameter int         FB_WIDTH  = 640,
  parameter int         FB_HEIGHT = 480,
  parameter int         ADDR_W    = 19,
  parameter logic [7:0] BG_COLOR  = 8'd0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [255:0]      sprite_bitmap,
  input  logic [7:0]        sprite_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ready
);

`ifdef BLIT_ERASE_EN
  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [7:0]     k_q, k_d;
  logic [9:0]     x_q, x_d, y_q, y_d;
  logic [255:0]   bmp_q, bmp_d;
  logic [7:0]     color_q, color_d;
`ifdef BLIT_ERASE_EN
  logic [9:0]     prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic           prev_valid_q, prev_valid_d;
`endif

  logic              scan, erase_phase, paint, clipped;
  logic [9:0]        base_x, base_y;
  logic [10:0]       px, py;
  logic [7:0]        pix_color;
  logic [ADDR_W-1:0] full_addr;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= 8'd0;
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      bmp_q        <= 256'd0;
      color_q      <= 8'd0;
`ifdef BLIT_ERASE_EN
      prev_x_q     <= 10'd0;
      prev_y_q     <= 10'd0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bmp_q        <= bmp_d;
      color_q      <= color_d;
`ifdef BLIT_ERASE_EN
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    bmp_d     = bmp_q;
    color_d   = color_q;
`ifdef BLIT_ERASE_EN
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    erase_phase  = (state_q == S_ERASE);
`else
    erase_phase  = 1'b0;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    fb_we     = 1'b0;
    fb_data   = 8'd0;
    fb_addr   = '0;
    scan      = (state_q == S_DRAW) || erase_phase;

    // Erase clears the old box unconditionally; draw uses the latched bitmap (MSB = top-left).
    base_x    = x_q;
    base_y    = y_q;
    paint     = bmp_q[~k_q];
    pix_color = color_q;
`ifdef BLIT_ERASE_EN
    if (erase_phase) begin
      base_x    = prev_x_q;
      base_y    = prev_y_q;
      paint     = 1'b1;
      pix_color = BG_COLOR;
    end
`endif
    px        = {1'b0, base_x} + {7'd0, k_q[3:0]};
    py        = {1'b0, base_y} + {7'd0, k_q[7:4]};
    clipped   = (px >= 11'(FB_WIDTH)) || (py >= 11'(FB_HEIGHT));
    full_addr = (ADDR_W'(py) << 9) + (ADDR_W'(py) << 7) + ADDR_W'(px);

    if (state_q == S_IDLE) begin
      if (start) begin
        x_d     = sprite_x;
        y_d     = sprite_y;
        bmp_d   = sprite_bitmap;
        color_d = sprite_color;
        k_d     = 8'd0;
`ifdef BLIT_ERASE_EN
        state_d = prev_valid_q ? S_ERASE : S_DRAW;
`else
        state_d = S_DRAW;
`endif
      end
    end else if (state_q == S_DONE) begin
      done    = 1'b1;
      state_d = S_IDLE;
    end else if (scan) begin
      busy  = 1'b1;
      fb_we = paint && !clipped;
      if (fb_we) begin
        fb_data = pix_color;
        fb_addr = full_addr;
      end
      // Counter only moves when the current pixel is a no-write or its write is accepted.
      if (!fb_we || fb_ready) begin
        k_d = k_q + 8'd1;
        if (k_q == 8'hFF) begin
          if (erase_phase) begin
            state_d = S_DRAW;
          end else begin
            state_d = S_DONE;
`ifdef BLIT_ERASE_EN
            prev_x_d     = x_q;
            prev_y_d     = y_q;
            prev_valid_d = 1'b1;
`endif
          end
        end
      end
    end else begin
      state_d = S_IDLE;
    end
  end

endmodule
